gpio_ctrl: RTL and testbench

- Memory-mapped GPIO peripheral for the rvcpu mother board; next generation of the fixed 4-LED / 4-switch board I/O.
- Parametrised LED and switch counts; per-switch synchroniser and debouncer; per-switch edge capture with a level interrupt to the CPU.
- Sits on the CPU data bus beside RAM; drives board LEDs and samples board switches.

---
 rtl/gpio_ctrl.sv | 107 ++++++++++
 tb/tb_gpio_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: memory-mapped LED/switch GPIO with debounced edge-capture interrupt; PWM dimming when GPIO_PWM_EN is defined
module gpio_ctrl #(
  parameter int N_LED = 4,
  parameter int N_SW = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_SW-1:0]   switch,
  output logic [N_LED-1:0]  led,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic              irq
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [ADDR_W-3:0] A_LED = 0;
  localparam logic [ADDR_W-3:0] A_SW = 1;
  localparam logic [ADDR_W-3:0] A_ES = 2;
  localparam logic [ADDR_W-3:0] A_EN = 3;
  localparam logic [ADDR_W-3:0] A_PWM = 4;
  logic [ADDR_W-3:0] wa;
  logic              wr;
  logic [N_SW-1:0]   s1, s2, deb, edge_set, edge_stat, irq_en;
  logic [CW-1:0]     cnt [N_SW];
  logic [N_LED-1:0]  led_out;
  logic [31:0]       rd, pwm_rd;
  logic              unused;
  assign wa = addr[ADDR_W-1:2];
  assign wr = req & we;
  assign unused = ^{addr[1:0], wdata};
  // a switch is accepted once its synchronised value has differed from the debounced level for the full window
  always_comb begin
    edge_set = '0;
    for (int k = 0; k < N_SW; k++) edge_set[k] = (s2[k] != deb[k]) && (cnt[k] == CNT_MAX);
  end
  // two-flop synchroniser, per-switch debounce counters and debounced levels
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
      deb <= '0;
      for (int k = 0; k < N_SW; k++) cnt[k] <= '0;
    end else begin
      s1 <= switch;
      s2 <= s1;
      deb <= deb ^ edge_set;
      for (int k = 0; k < N_SW; k++) cnt[k] <= (s2[k] == deb[k] || edge_set[k]) ? '0 : cnt[k] + CW'(1);
    end
  end
  // control registers; a new edge beats a simultaneous W1C on the same bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_out <= '0;
      irq_en <= '0;
      edge_stat <= '0;
    end else begin
      if (wr && wa == A_LED) led_out <= wdata[N_LED-1:0];
      if (wr && wa == A_EN) irq_en <= wdata[N_SW-1:0];
      edge_stat <= (edge_stat & ~((wr && wa == A_ES) ? wdata[N_SW-1:0] : '0)) | edge_set;
    end
  end
  // read mux sees register values from before the current access edge
  always_comb begin
    rd = wa == A_LED ? 32'(led_out) :
         wa == A_SW  ? 32'(deb) :
         wa == A_ES  ? 32'(edge_stat) :
         wa == A_EN  ? 32'(irq_en) :
         wa == A_PWM ? pwm_rd : '0;
  end
  // single-cycle bus response and registered interrupt
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready <= 1'b0;
      rdata <= '0;
      irq <= 1'b0;
    end else begin
      ready <= req;
      rdata <= (req && !we) ? rd : '0;
      irq <= |(edge_stat & irq_en);
    end
  end
`ifdef GPIO_PWM_EN
  logic [7:0] duty, pwm_cnt;
  assign pwm_rd = 32'(duty);
  // free-running PWM counter gates the LED outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      duty <= 8'hFF;
      pwm_cnt <= '0;
      led <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      if (wr && wa == A_PWM) duty <= wdata[7:0];
      led <= led_out & {N_LED{pwm_cnt < duty}};
    end
  end
`else
  assign pwm_rd = '0;
  assign led = led_out;
`endif
endmodule

// File: tb/tb_gpio_ctrl.sv
// tb_gpio_ctrl: directed scenarios plus randomized run against a behavioural GPIO model
module tb_gpio_ctrl;
  localparam int D = 16;
  logic        clk = 0, reset = 1, req = 0, we = 0;
  logic [3:0]  switch = '0;
  logic [4:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  led;
  logic [31:0] rdata;
  logic        ready, irq;
  int n_chk = 0, n_pass = 0;
  logic [3:0] m_led, m_en, m_es, m_deb;
  logic [3:0] hist[$];

  gpio_ctrl #(.N_LED(4), .N_SW(4), .DEBOUNCE_CYCLES(D), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .switch(switch), .led(led), .req(req), .we(we),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic w, input logic [4:0] a, input logic [31:0] d, output logic r, output logic [31:0] q);
    req = 1; we = w; addr = a; wdata = d;
    tick();
    r = ready; q = rdata;
    req = 0; we = 0;
  endtask

  task automatic test_reset();
    logic r; logic [31:0] q;
    #1 reset = 0;
    repeat (3) tick();
    n_chk++; if (led !== 4'h0) $display("FAIL reset_led: got %h exp 0", led); else n_pass++;
    n_chk++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b exp 0", irq); else n_pass++;
    n_chk++; if (ready !== 1'b0) $display("FAIL reset_ready: got %b exp 0", ready); else n_pass++;
    n_chk++; if (rdata !== 32'h0) $display("FAIL reset_rdata: got %h exp 0", rdata); else n_pass++;
    reset = 1;
    tick();
    for (int a = 0; a < 32; a += 4) begin
      bus(0, 5'(a), 0, r, q);
      n_chk++; if (r !== 1'b1) $display("FAIL reset_read_ready@%0h: got %b exp 1", a, r); else n_pass++;
      n_chk++; if (q !== 32'h0) $display("FAIL reset_read@%0h: got %h exp 0", a, q); else n_pass++;
    end
  endtask

  task automatic test_led();
    logic r; logic [31:0] q;
    bus(1, 5'h00, 32'hFFFF_FFFA, r, q);
    n_chk++; if (led !== 4'hA) $display("FAIL led_out: got %h exp a", led); else n_pass++;
    bus(0, 5'h00, 0, r, q);
    n_chk++; if (q !== 32'hA) $display("FAIL led_read: got %h exp a", q); else n_pass++;
  endtask

  task automatic test_back_to_back();
    req = 1; we = 1; addr = 5'h00; wdata = 32'h5;
    tick();
    n_chk++; if (ready !== 1'b1 || rdata !== 32'h0) $display("FAIL b2b_write: got %b/%h exp 1/0", ready, rdata); else n_pass++;
    we = 0;
    tick();
    n_chk++; if (ready !== 1'b1 || rdata !== 32'h5) $display("FAIL b2b_read_led: got %b/%h exp 1/5", ready, rdata); else n_pass++;
    addr = 5'h0D;
    tick();
    n_chk++; if (ready !== 1'b1 || rdata !== 32'h0) $display("FAIL b2b_read_en: got %b/%h exp 1/0", ready, rdata); else n_pass++;
    req = 0;
    tick();
    n_chk++; if (ready !== 1'b0 || rdata !== 32'h0) $display("FAIL b2b_idle: got %b/%h exp 0/0", ready, rdata); else n_pass++;
    n_chk++; if (led !== 4'h5) $display("FAIL b2b_led: got %h exp 5", led); else n_pass++;
  endtask

  task automatic test_glitch();
    logic r; logic [31:0] q;
    switch[2] = 1;
    repeat (10) tick();
    switch[2] = 0;
    repeat (30) tick();
    bus(0, 5'h04, 0, r, q);
    n_chk++; if (q !== 32'h0) $display("FAIL glitch_sw: got %h exp 0", q); else n_pass++;
    bus(0, 5'h08, 0, r, q);
    n_chk++; if (q !== 32'h0) $display("FAIL glitch_edge: got %h exp 0", q); else n_pass++;
  endtask

  task automatic test_latency();
    switch[2] = 1;
    req = 1; we = 0; addr = 5'h04;
    for (int j = 1; j <= 20; j++) begin
      tick();
      n_chk++; if (rdata !== (j >= D + 3 ? 32'h4 : 32'h0)) $display("FAIL latency_sw@%0d: got %h exp %h", j, rdata, (j >= D + 3 ? 32'h4 : 32'h0)); else n_pass++;
    end
    req = 0;
  endtask

  task automatic test_irq();
    logic r; logic [31:0] q;
    switch[2] = 0;
    repeat (20) tick();
    bus(1, 5'h08, 32'hF, r, q);
    bus(1, 5'h0C, 32'h4, r, q);
    n_chk++; if (irq !== 1'b0) $display("FAIL irq_idle: got %b exp 0", irq); else n_pass++;
    switch[2] = 1;
    req = 1; we = 0; addr = 5'h08;
    for (int j = 1; j <= 20; j++) begin
      tick();
      n_chk++; if (rdata !== (j >= D + 3 ? 32'h4 : 32'h0)) $display("FAIL irq_edge@%0d: got %h exp %h", j, rdata, (j >= D + 3 ? 32'h4 : 32'h0)); else n_pass++;
      n_chk++; if (irq !== (j >= D + 3)) $display("FAIL irq_rise@%0d: got %b exp %b", j, irq, (j >= D + 3)); else n_pass++;
    end
    req = 0;
    bus(1, 5'h08, 32'h4, r, q);
    n_chk++; if (irq !== 1'b1) $display("FAIL irq_hold: got %b exp 1", irq); else n_pass++;
    tick();
    n_chk++; if (irq !== 1'b0) $display("FAIL irq_fall: got %b exp 0", irq); else n_pass++;
    bus(0, 5'h08, 0, r, q);
    n_chk++; if (q !== 32'h0) $display("FAIL irq_cleared: got %h exp 0", q); else n_pass++;
  endtask

  task automatic test_w1c_collision();
    logic r; logic [31:0] q;
    switch[1] = 1;
    repeat (D + 1) tick();
    bus(1, 5'h08, 32'h2, r, q);
    bus(0, 5'h08, 0, r, q);
    n_chk++; if (q !== 32'h2) $display("FAIL w1c_collision: got %h exp 2", q); else n_pass++;
    bus(1, 5'h08, 32'h2, r, q);
    bus(0, 5'h08, 0, r, q);
    n_chk++; if (q !== 32'h0) $display("FAIL w1c_clear: got %h exp 0", q); else n_pass++;
  endtask

  task automatic test_mid_reset();
    switch = 4'b0001;
    req = 1; we = 0; addr = 5'h00;
    #2 reset = 0;
    tick();
    n_chk++; if (ready !== 1'b0) $display("FAIL midrst_ready: got %b exp 0", ready); else n_pass++;
    n_chk++; if (led !== 4'h0) $display("FAIL midrst_led: got %h exp 0", led); else n_pass++;
    req = 0;
    tick();
    reset = 1;
    req = 1; addr = 5'h08;
    for (int j = 1; j <= 20; j++) begin
      tick();
      n_chk++; if (rdata !== (j >= D + 3 ? 32'h1 : 32'h0)) $display("FAIL midrst_edge@%0d: got %h exp %h", j, rdata, (j >= D + 3 ? 32'h1 : 32'h0)); else n_pass++;
    end
    req = 0;
  endtask

  task automatic test_random();
    int w;
    logic [31:0] rv, e_rd;
    logic e_rdy, e_irq, stable;
    logic [3:0] flip, clr;
    reset = 0;
    switch = '0;
    tick();
    m_led = 0; m_en = 0; m_es = 0; m_deb = 0;
    hist = {};
    repeat (D + 2) hist.push_back(4'h0);
    reset = 1;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 7) == 0) switch = switch ^ 4'(1 << $urandom_range(0, 3));
      req = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      addr = 5'($urandom_range(0, 31));
      wdata = $urandom;
      w = int'(addr[4:2]);
      rv = w == 0 ? 32'(m_led) : w == 1 ? 32'(m_deb) : w == 2 ? 32'(m_es) : w == 3 ? 32'(m_en) : 32'h0;
      e_rdy = req;
      e_rd = (req && !we) ? rv : 32'h0;
      e_irq = |(m_es & m_en);
      hist.push_front(switch);
      void'(hist.pop_back());
      flip = 0;
      for (int k = 0; k < 4; k++) begin
        stable = 1;
        for (int j = 2; j <= D + 1; j++) if (hist[j][k] == m_deb[k]) stable = 0;
        flip[k] = stable;
      end
      clr = (req && we && w == 2) ? wdata[3:0] : 4'h0;
      if (req && we && w == 0) m_led = wdata[3:0];
      if (req && we && w == 3) m_en = wdata[3:0];
      m_es = (m_es & ~clr) | flip;
      m_deb = m_deb ^ flip;
      tick();
      n_chk++; if (ready !== e_rdy) $display("FAIL rand_ready@%0d: got %b exp %b", c, ready, e_rdy); else n_pass++;
      n_chk++; if (rdata !== e_rd) $display("FAIL rand_rdata@%0d: got %h exp %h", c, rdata, e_rd); else n_pass++;
      n_chk++; if (led !== m_led) $display("FAIL rand_led@%0d: got %h exp %h", c, led, m_led); else n_pass++;
      n_chk++; if (irq !== e_irq) $display("FAIL rand_irq@%0d: got %b exp %b", c, irq, e_irq); else n_pass++;
    end
    req = 0;
  endtask

  initial begin
    test_reset();
    test_led();
    test_back_to_back();
    test_glitch();
    test_latency();
    test_irq();
    test_w1c_collision();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
